// File: rtl/spn_stride.sv
// spn_stride: streaming stride-permutation network.
//
// Collects blocks of N = 2**LOG_N words arriving PARA words per beat into
// a double buffer and emits each block permuted by its own stride
// S = 2**stride_log. The stride is latched on beat 0 of the block.
// Output index k reads input index (k mod (N/S))*S + floor(k/(N/S)).
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   input_stream   PARA input lanes; lane l of beat c is block index c*PARA+l
//   valid_in       qualifies input_stream
//   stride_log     log2 of the stride, sampled on beat 0 of each block
//   output_stream  PARA permuted output lanes, registered, zero when idle
//   valid_out      qualifies output_stream
//   stride_err     sticky: a stride_log > LOG_N was sampled (cleared by reset)
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no block waiting to be read
// DRAIN | rd_cnt running, one output beat per cycle

module spn_stride #(
    parameter int DATA_WIDTH = 32,
    parameter int PARA       = 16,
    parameter int LOG_N      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         input_stream [PARA-1:0],
    input  logic                          valid_in,
    input  logic [$clog2(LOG_N+1)-1:0]    stride_log,
    output logic [DATA_WIDTH-1:0]         output_stream [PARA-1:0],
    output logic                          valid_out,
    output logic                          stride_err
);

    localparam int N     = 1 << LOG_N;
    localparam int M     = N / PARA;
    localparam int LOG_P = $clog2(PARA);
    localparam int CW    = LOG_N - LOG_P;
    localparam int SW    = $clog2(LOG_N + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           wr_cnt_q;
    logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
    logic                    wr_buf_q;
    logic                    rd_buf_q, rd_buf_d;
    logic [SW-1:0]           stride_q [2];
    logic                    stride_err_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   out_q [PARA-1:0];
    logic [DATA_WIDTH-1:0]   out_d [PARA-1:0];
    logic [DATA_WIDTH-1:0]   buf_q [2][N];
    logic [DATA_WIDTH-1:0]   view  [N];

    logic                    wr_last;
    logic                    blk_done;
    logic                    stride_ok;
    logic [SW-1:0]           rd_stride;

    assign wr_last   = (wr_cnt_q == CW'(M - 1));
    assign blk_done  = valid_in && wr_last;
    assign stride_ok = (stride_log <= SW'(LOG_N));

    // Input index feeding output index k = {beat, lane} for stride 2**s.
    // (k & (N/S-1)) << s stays below N and k >> (LOG_N-s) stays below S,
    // so the two fields can be OR-ed together.
    function automatic logic [LOG_N-1:0] src_idx(input logic [CW-1:0] beat,
                                                 input int            lane,
                                                 input logic [SW-1:0] s);
        logic [LOG_N-1:0] k, lo, hi;
        k  = {beat, LOG_P'(lane)};
        lo = k & LOG_N'((N >> s) - 1);
        hi = k >> (SW'(LOG_N) - s);
        return (lo << s) | hi;
    endfunction

    // ---------------- read-side FSM ----------------
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_buf_d = rd_buf_q;
        if (blk_done) begin
            state_d  = DRAIN;
            rd_cnt_d = '0;
            rd_buf_d = wr_buf_q;
        end else if (state_q == DRAIN) begin
            if (rd_cnt_q == CW'(M - 1)) begin
                state_d  = IDLE;
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    // The output is registered, so the beat for the next cycle is chosen from
    // the next read pointer. On the completion cycle the last beat is not yet
    // in the buffer, hence the overlay of the incoming beat.
    assign rd_stride = stride_q[rd_buf_d];

    always_comb begin
        for (int w = 0; w < N; w++) begin
            view[w] = buf_q[rd_buf_d][w];
        end
        if (valid_in && (wr_buf_q == rd_buf_d)) begin
            for (int l = 0; l < PARA; l++) begin
                view[{wr_cnt_q, LOG_P'(l)}] = input_stream[l];
            end
        end
        for (int l = 0; l < PARA; l++) begin
            out_d[l] = '0;
            if (state_d == DRAIN) begin
                out_d[l] = view[src_idx(rd_cnt_d, l, rd_stride)];
            end
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_buf_q     <= 1'b0;
            rd_buf_q     <= 1'b0;
            stride_q[0]  <= '0;
            stride_q[1]  <= '0;
            stride_err_q <= 1'b0;
            valid_q      <= 1'b0;
            for (int l = 0; l < PARA; l++) begin
                out_q[l] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            rd_buf_q <= rd_buf_d;
            valid_q  <= (state_d == DRAIN);
            out_q    <= out_d;
            if (valid_in) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + CW'(1);
                if (wr_last) begin
                    wr_buf_q <= ~wr_buf_q;
                end
                if (wr_cnt_q == '0) begin
                    stride_q[wr_buf_q] <= stride_ok ? stride_log : '0;
                    if (!stride_ok) begin
                        stride_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- data buffer (contents not reset) ----------------
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int l = 0; l < PARA; l++) begin
                buf_q[wr_buf_q][{wr_cnt_q, LOG_P'(l)}] <= input_stream[l];
            end
        end
    end

    assign output_stream = out_q;
    assign valid_out     = valid_q;
    assign stride_err    = stride_err_q;

endmodule
